// File: rtl/pi1_arbiter_pkg.sv
// Shared pi1 op encodings, arbiter FSM states and width helpers.
// The op constants match the ones the pu core drives.
package pi1_arbiter_pkg;

  localparam logic [1:0] MEMNOOP        = 2'b00;
  localparam logic [1:0] MEMWRITEOP     = 2'b01;
  localparam logic [1:0] MEMREADOP      = 2'b10;
  localparam logic [1:0] MEMREADWRITEOP = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // An index into a set of masters always needs at least one bit.
  function automatic int selbits(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/pi1_arbiter_if.sv
// pi1 bundle between the cores, the arbiter and the downstream slave.
// Signal names are as seen from the arbiter; modport slave is the arbiter side.
interface pi1_arbiter_if #(
  parameter int MASTERCOUNT = 2,
  parameter int ARCHBITSZ   = 32
);
  import pi1_arbiter_pkg::*;

  localparam int ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ / 8);
  localparam int SELBITSZ  = ARCHBITSZ / 8;

  logic [2*MASTERCOUNT-1:0]         m_pi1_op_i;
  logic [ADDRBITSZ*MASTERCOUNT-1:0] m_pi1_addr_i;
  logic [ARCHBITSZ*MASTERCOUNT-1:0] m_pi1_data_i;
  logic [SELBITSZ*MASTERCOUNT-1:0]  m_pi1_sel_i;
  logic [ARCHBITSZ-1:0]             m_pi1_data_o;
  logic [MASTERCOUNT-1:0]           m_pi1_rdy_o;
  logic [1:0]                       s_pi1_op_o;
  logic [ADDRBITSZ-1:0]             s_pi1_addr_o;
  logic [ARCHBITSZ-1:0]             s_pi1_data_o;
  logic [SELBITSZ-1:0]              s_pi1_sel_o;
  logic [ARCHBITSZ-1:0]             s_pi1_data_i;
  logic                             s_pi1_rdy_i;

  modport slave (
    input  m_pi1_op_i, m_pi1_addr_i, m_pi1_data_i, m_pi1_sel_i,
    input  s_pi1_data_i, s_pi1_rdy_i,
    output m_pi1_data_o, m_pi1_rdy_o,
    output s_pi1_op_o, s_pi1_addr_o, s_pi1_data_o, s_pi1_sel_o
  );

  modport master (
    output m_pi1_op_i, m_pi1_addr_i, m_pi1_data_i, m_pi1_sel_i,
    output s_pi1_data_i, s_pi1_rdy_i,
    input  m_pi1_data_o, m_pi1_rdy_o,
    input  s_pi1_op_o, s_pi1_addr_o, s_pi1_data_o, s_pi1_sel_o
  );

endinterface

// File: rtl/pi1_arbiter_rr_pick.sv
// Combinational rotating-priority picker: first requester after last_i, with wrap.
// vld_o is low when no requester is present; idx_o is then 0.
module pi1_arbiter_rr_pick #(
  parameter int N = 2,
  parameter int W = 1
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] last_i,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  logic [W:0]   sum;
  logic [W-1:0] pos;

  // Walk from the farthest position back to the nearest so the nearest requester wins.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int k = N; k >= 1; k--) begin
      sum = {1'b0, last_i} + (W+1)'(k);
      if (sum >= (W+1)'(N)) sum = sum - (W+1)'(N);
      pos = sum[W-1:0];
      if (req_i[pos]) begin
        idx_o = pos;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pi1_arbiter.sv
// Round-robin arbiter sharing one pi1 slave between MASTERCOUNT masters, one transaction in flight.
// Requests forward combinationally in IDLE; the owner keeps the bus until its completion cycle.
module pi1_arbiter
  import pi1_arbiter_pkg::*;
#(
  parameter int  MASTERCOUNT = 2,
  parameter int  ARCHBITSZ   = 32,
  localparam int MSELBITSZ   = selbits(MASTERCOUNT),
  localparam int ADDRBITSZ   = ARCHBITSZ - clog2(ARCHBITSZ / 8),
  localparam int SELBITSZ    = ARCHBITSZ / 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pi1_arbiter_if.slave         bus,
  output logic [MSELBITSZ-1:0] gnt_o
);

  state_t                 state_q, state_d;
  logic [MSELBITSZ-1:0]   owner_q, owner_d;
  logic [MSELBITSZ-1:0]   last_q, last_d;
  logic [MASTERCOUNT-1:0] req;
  logic [MSELBITSZ-1:0]   cand_idx;
  logic                   cand_vld;
  logic [MSELBITSZ-1:0]   mux_idx;

  always_comb begin
    req = '0;
    for (int i = 0; i < MASTERCOUNT; i++) begin
      req[i] = (bus.m_pi1_op_i[2*i +: 2] != MEMNOOP);
    end
  end

  pi1_arbiter_rr_pick #(
    .N (MASTERCOUNT),
    .W (MSELBITSZ)
  ) u_pick (
    .req_i  (req),
    .last_i (last_q),
    .idx_o  (cand_idx),
    .vld_o  (cand_vld)
  );

  assign mux_idx = (state_q == BUSY) ? owner_q : cand_idx;

  // s_pi1_op_o depends only on state and master ops, never on s_pi1_rdy_i.
  always_comb begin
    bus.s_pi1_op_o   = MEMNOOP;
    bus.m_pi1_rdy_o  = '0;
    bus.s_pi1_addr_o = bus.m_pi1_addr_i[int'(mux_idx)*ADDRBITSZ +: ADDRBITSZ];
    bus.s_pi1_data_o = bus.m_pi1_data_i[int'(mux_idx)*ARCHBITSZ +: ARCHBITSZ];
    bus.s_pi1_sel_o  = bus.m_pi1_sel_i[int'(mux_idx)*SELBITSZ +: SELBITSZ];
    bus.m_pi1_data_o = bus.s_pi1_data_i;
    if (!rst_i) begin
      if (state_q == BUSY) begin
        bus.m_pi1_rdy_o[owner_q] = bus.s_pi1_rdy_i;
      end else if (cand_vld) begin
        bus.s_pi1_op_o            = bus.m_pi1_op_i[2*int'(cand_idx) +: 2];
        bus.m_pi1_rdy_o[cand_idx] = bus.s_pi1_rdy_i;
      end
    end
  end

  always_comb begin
    if (state_q == BUSY)  gnt_o = owner_q;
    else if (cand_vld)    gnt_o = cand_idx;
    else                  gnt_o = last_q;
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.s_pi1_rdy_i && cand_vld) begin
          owner_d = cand_idx;
          last_d  = cand_idx;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.s_pi1_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // last resets to the top index so master 0 holds first priority.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= MSELBITSZ'(MASTERCOUNT - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: tb/tb_pi1_arbiter.sv
// Scoreboard bench for pi1_arbiter with four masters: expected rdy events are queued
// by the stimulus and consumed by a monitor on every cycle where any master sees rdy.
module tb_pi1_arbiter;
  import pi1_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 30;
  localparam int SW = 4;

  typedef struct packed {
    logic [N-1:0]  rdy;
    logic [1:0]    gnt;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] gnt;

  pi1_arbiter_if #(.MASTERCOUNT(N), .ARCHBITSZ(DW)) bus ();

  pi1_arbiter #(.MASTERCOUNT(N), .ARCHBITSZ(DW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .gnt_o (gnt)
  );

  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  n_vec = 0;
  int  n_err = 0;

  function automatic logic [AW-1:0] addr_of(input int m);
    return AW'(32'h1000 + m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int m, input logic [1:0] op);
    bus.m_pi1_op_i[2*m +: 2] = op;
  endtask

  task automatic expect_ev(input int m, input int g, input logic [1:0] op,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
    ev_t e;
    e.rdy  = N'(1 << m);
    e.gnt  = 2'(g);
    e.op   = op;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Monitor: every cycle with a rdy pulse must match the next queued event.
  initial begin
    ev_t got, want;
    forever begin
      @(negedge clk);
      if (|bus.m_pi1_rdy_o) begin
        got.rdy  = bus.m_pi1_rdy_o;
        got.gnt  = gnt;
        got.op   = bus.s_pi1_op_o;
        got.addr = bus.s_pi1_addr_o;
        got.data = bus.m_pi1_data_o;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rdy at %0t: rdy=%b gnt=%0d op=%b addr=%h data=%h",
                   $time, got.rdy, got.gnt, got.op, got.addr, got.data);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_err++;
            $display("FAIL rdy_event at %0t: got rdy=%b gnt=%0d op=%b addr=%h data=%h, expected rdy=%b gnt=%0d op=%b addr=%h data=%h",
                     $time, got.rdy, got.gnt, got.op, got.addr, got.data,
                     want.rdy, want.gnt, want.op, want.addr, want.data);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.m_pi1_op_i   = '0;
    bus.m_pi1_sel_i  = '1;
    bus.s_pi1_data_i = '0;
    bus.s_pi1_rdy_i  = 1'b1;
    for (int m = 0; m < N; m++) begin
      bus.m_pi1_addr_i[m*AW +: AW] = addr_of(m);
      bus.m_pi1_data_i[m*DW +: DW] = DW'(32'hA000_0000 + m);
    end

    // Reset forces outputs quiet even with requests and slave ready.
    set_op(0, MEMREADOP);
    set_op(1, MEMREADOP);
    tick();
    @(negedge clk);
    chk("reset_s_op", 64'(bus.s_pi1_op_o), 64'(MEMNOOP));
    chk("reset_m_rdy", 64'(bus.m_pi1_rdy_o), 64'h0);
    tick();
    rst = 1'b0;
    expect_ev(0, 0, MEMREADOP, addr_of(0), 32'h0);
    @(negedge clk);
    chk("post_reset_gnt", 64'(gnt), 64'd0);
    tick();
    set_op(0, MEMNOOP);
    expect_ev(0, 0, MEMNOOP, addr_of(0), 32'h0);
    tick();
    expect_ev(1, 1, MEMREADOP, addr_of(1), 32'h0);
    tick();
    set_op(1, MEMNOOP);
    expect_ev(1, 1, MEMNOOP, addr_of(1), 32'h0);
    tick();

    // Contention: all four hold writes, slave always ready.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int m = 0; m < N; m++) set_op(m, MEMWRITEOP);
    for (int k = 0; k < 5; k++) begin
      expect_ev(k % N, k % N, MEMWRITEOP, addr_of(k % N), 32'h0);
      tick();
      expect_ev(k % N, k % N, MEMNOOP, addr_of(k % N), 32'h0);
      tick();
    end
    for (int m = 0; m < N; m++) set_op(m, MEMNOOP);

    // Read with a three-cycle stall; master 0 waits its turn behind master 1.
    bus.m_pi1_addr_i[1*AW +: AW] = AW'(32'h100);
    set_op(0, MEMWRITEOP);
    set_op(1, MEMREADOP);
    expect_ev(1, 1, MEMREADOP, AW'(32'h100), 32'h0);
    tick();
    set_op(1, MEMNOOP);
    bus.s_pi1_rdy_i = 1'b0;
    @(negedge clk);
    chk("stall_gnt", 64'(gnt), 64'd1);
    chk("stall_s_op", 64'(bus.s_pi1_op_o), 64'(MEMNOOP));
    tick();
    tick();
    tick();
    bus.s_pi1_rdy_i  = 1'b1;
    bus.s_pi1_data_i = 32'hDEAD_BEEF;
    expect_ev(1, 1, MEMNOOP, AW'(32'h100), 32'hDEAD_BEEF);
    tick();
    bus.s_pi1_data_i = 32'h0;
    expect_ev(0, 0, MEMWRITEOP, addr_of(0), 32'h0);
    tick();
    set_op(0, MEMNOOP);
    expect_ev(0, 0, MEMNOOP, addr_of(0), 32'h0);
    tick();

    // Withdrawal: master 0 drops its op before any acceptance.
    bus.s_pi1_rdy_i = 1'b0;
    set_op(0, MEMWRITEOP);
    @(negedge clk);
    chk("withdraw_cand0_gnt", 64'(gnt), 64'd0);
    tick();
    set_op(0, MEMNOOP);
    set_op(1, MEMWRITEOP);
    @(negedge clk);
    chk("withdraw_cand1_gnt", 64'(gnt), 64'd1);
    chk("withdraw_cand1_op", 64'(bus.s_pi1_op_o), 64'(MEMWRITEOP));
    tick();
    bus.s_pi1_rdy_i = 1'b1;
    expect_ev(1, 1, MEMWRITEOP, AW'(32'h100), 32'h0);
    tick();
    set_op(1, MEMNOOP);
    expect_ev(1, 1, MEMNOOP, AW'(32'h100), 32'h0);
    tick();

    // Reset while master 2 waits for completion; master 0 then has priority.
    set_op(2, MEMWRITEOP);
    expect_ev(2, 2, MEMWRITEOP, addr_of(2), 32'h0);
    tick();
    set_op(2, MEMNOOP);
    bus.s_pi1_rdy_i = 1'b0;
    tick();
    rst = 1'b1;
    set_op(0, MEMWRITEOP);
    set_op(2, MEMWRITEOP);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy_gnt", 64'(gnt), 64'd0);
    chk("rst_busy_op", 64'(bus.s_pi1_op_o), 64'(MEMWRITEOP));
    chk("rst_busy_addr", 64'(bus.s_pi1_addr_o), 64'(addr_of(0)));
    tick();
    bus.s_pi1_rdy_i = 1'b1;
    expect_ev(0, 0, MEMWRITEOP, addr_of(0), 32'h0);
    tick();
    set_op(0, MEMNOOP);
    expect_ev(0, 0, MEMNOOP, addr_of(0), 32'h0);
    tick();
    expect_ev(2, 2, MEMWRITEOP, addr_of(2), 32'h0);
    tick();
    set_op(2, MEMNOOP);
    expect_ev(2, 2, MEMNOOP, addr_of(2), 32'h0);
    tick();

    // Wrap: master 3 alone, granted twice in a row including from last=3.
    set_op(3, MEMWRITEOP);
    for (int r = 0; r < 2; r++) begin
      expect_ev(3, 3, MEMWRITEOP, addr_of(3), 32'h0);
      tick();
      expect_ev(3, 3, MEMNOOP, addr_of(3), 32'h0);
      tick();
    end
    set_op(3, MEMNOOP);
    tick();
    @(negedge clk);
    chk("idle_gnt_last", 64'(gnt), 64'd3);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pi1_arbiter.md
# pi1_arbiter

- Round-robin arbiter that shares one pi1 slave port (memory/device interconnect) between MASTERCOUNT pu cores.
- Each core's pi1 master port connects to one arbiter master port; the arbiter's slave-facing port connects to the downstream memory controller.
- Exactly one transaction is outstanding at a time.
- The core that issued it owns the bus until its response completes.

## Interface
Parameters:
- MASTERCOUNT, 2, number of pi1 masters (≥2); index width MSELBITSZ = clog2(MASTERCOUNT), minimum 1.
- ARCHBITSZ, 32, data width; ADDRBITSZ = ARCHBITSZ - clog2(ARCHBITSZ/8).

Ports:
- clk_i  in  1  single clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- m_pi1_op_i  in  2*MASTERCOUNT  per-master op (MEMNOOP=00, MEMWRITEOP=01, MEMREADOP=10, MEMREADWRITEOP=11); master i in bits [2i+1:2i].
- m_pi1_addr_i  in  ADDRBITSZ*MASTERCOUNT  per-master word address.
- m_pi1_data_i  in  ARCHBITSZ*MASTERCOUNT  per-master write data.
- m_pi1_sel_i  in  (ARCHBITSZ/8)*MASTERCOUNT  per-master byte selects.
- m_pi1_data_o  out  ARCHBITSZ  read data, broadcast to all masters.
- m_pi1_rdy_o  out  MASTERCOUNT  per-master ready.
- s_pi1_op_o  out  2  op to slave.
- s_pi1_addr_o  out  ADDRBITSZ  address to slave.
- s_pi1_data_o  out  ARCHBITSZ  write data to slave.
- s_pi1_sel_o  out  ARCHBITSZ/8  byte selects to slave.
- s_pi1_data_i  in  ARCHBITSZ  read data from slave.
- s_pi1_rdy_i  in  1  slave ready.
- gnt_o  out  MSELBITSZ  index of the current or last owner, for debug.

## Operation
- pi1 rule:
  - A request is accepted in a cycle where op≠MEMNOOP and rdy=1.
  - It completes at the next cycle, strictly later, in which the slave rdy=1.
  - For MEMREADOP and MEMREADWRITEOP, read data is valid in the completion cycle.
- States are IDLE and BUSY; register `owner`; register `last`, the most recent accepted master.
- Behaviour in IDLE:
  - Candidate c is the first i with m_op[i]≠MEMNOOP, scanning (last+1) mod MASTERCOUNT upward with wrap.
  - If no master requests, s_pi1_op_o=MEMNOOP.
  - Otherwise the s_* outputs are c's op/addr/data/sel, forwarded combinationally.
  - m_pi1_rdy_o[c]=s_pi1_rdy_i; all other rdy bits are 0.
  - On s_rdy=1 with c valid: owner<=c, last<=c, state<=BUSY.
  - The candidate is re-evaluated every IDLE cycle; no grant is locked before acceptance.
- Behaviour in BUSY:
  - s_pi1_op_o=MEMNOOP; addr/data/sel hold owner's values.
  - m_pi1_rdy_o[owner]=s_pi1_rdy_i; all others 0.
  - On s_rdy=1: completion, state<=IDLE.
- m_pi1_data_o = s_pi1_data_i always. Masters qualify it with their own rdy.
- gnt_o = owner in BUSY, c in IDLE with a valid candidate, otherwise last.
- Boundary conditions:
  - All masters requesting: grants rotate strictly 0,1,…,N-1,0.
  - Single requester: it wins every time.
  - Wrap from last=N-1 goes to 0.
  - A master that withdraws its op in IDLE before acceptance is simply skipped.
  - s_rdy=0 indefinitely: the arbiter stays in its current state.
  - rst_i mid-transaction: the transaction is abandoned. The slave shares rst_i.

## Timing
- During rst_i and on the following first cycle: state=IDLE, last=MASTERCOUNT-1 (master 0 has first priority), owner=0.
- While rst_i is high, outputs are forced to s_pi1_op_o=MEMNOOP and m_pi1_rdy_o=0.
- Request-to-slave latency: 0 cycles (combinational path m_op→s_op in IDLE).
- Minimum transaction length: 2 cycles (accept, complete).
- The completion cycle issues MEMNOOP, so the next acceptance is earliest the following cycle.
- Peak throughput: 1 transaction per 2 cycles.
- No combinational path from s_pi1_rdy_i to s_pi1_op_o.

## Structure
- Shared package/include holds:
  - MEMNOOP/MEMWRITEOP/MEMREADOP/MEMREADWRITEOP, the same constants the pu uses;
  - clog2.
- Natural sub-module: pi1_rr_pick, a combinational rotating priority picker.
  - Inputs: req vector, last index.
  - Outputs: idx, valid.
- Top level holds the FSM, registers and muxes.
- Target size: about 150–250 lines.

## Test plan
- Reset, N=2:
  - During reset: s_op=00, rdy_o=00.
  - First cycle after reset, both masters issue MEMREADOP: master 0 is forwarded first; gnt_o=0.
- Contention, N=4:
  - All four masters hold MEMWRITEOP with slave rdy=1 always.
  - Accept order 0,1,2,3,0 on cycles 0,2,4,6,8; each completes one cycle after acceptance.
- Read data:
  - Master 1 reads addr 0x100; slave holds rdy=0 for 3 cycles, then rdy=1 with data 0xDEADBEEF.
  - m_rdy_o[1]=1 only in that cycle; m_data_o=0xDEADBEEF; master 0's rdy stays 0 throughout.
- Withdrawal:
  - Master 0 requests while slave rdy=0, then drops to MEMNOOP; master 1 requests.
  - Master 1 is accepted when rdy rises; master 0 never sees rdy.
- Reset mid-BUSY: assert rst_i while waiting for completion.
  - Next cycle: IDLE, last=N-1.
  - A pending request from master 2 is not granted ahead of master 0's request.
- Wrap: last=N-1 with only master N-1 requesting.
  - Master N-1 is granted again; no starvation, no glitch on the other rdy bits.
